// File: rtl/ram8x8_pkg.sv
// Shared constants and types for the 8x8 ROM/RAM slot.
// The geometry matches the ROM, so either can fill the same data-path slot.
// Contents: DATA_W/ADDR_W/DEPTH, the reset word, address/data typedefs,
// the read-entry struct, the mux2 used by the read tree and the 3:8 decoder.
package ram8x8_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 3;
  localparam int unsigned DEPTH  = 32'(1) << ADDR_W;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [ADDR_W-1:0] addr_t;

  localparam data_t RST_VAL_DEFAULT = 8'h00;

  // One storage word plus its written-since-reset flag.
  typedef struct packed {
    logic  vld;
    data_t data;
  } entry_t;

  // Two-way selector for the read tree.
  function automatic entry_t mux2(input entry_t a, input entry_t b, input logic sel);
    return sel ? b : a;
  endfunction

  // One-hot decode of a word address.
  function automatic logic [DEPTH-1:0] dec_onehot(input addr_t a);
    logic [DEPTH-1:0] dec;
    dec    = '0;
    dec[a] = 1'b1;
    return dec;
  endfunction

endpackage

// File: rtl/ram8x8_reg8_en.sv
// One RAM word: DATA_W-bit register plus valid bit, synchronous reset, load enable.
// Ports: clk, rst (sync, active-high), en (load), din (write data),
//        q (registered {vld, data}).
module ram8x8_reg8_en
  import ram8x8_pkg::*;
#(
  parameter data_t RST_VAL = RST_VAL_DEFAULT
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   en,
  input  data_t  din,
  output entry_t q
);

  data_t word_q, word_d;
  logic  vld_q,  vld_d;

  // Next-state: load on enable, otherwise hold.
  always_comb begin
    word_d = word_q;
    vld_d  = vld_q;
    if (en) begin
      word_d = din;
      vld_d  = 1'b1;
    end
  end

  // Reset takes priority over a write in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      word_q <= RST_VAL;
      vld_q  <= 1'b0;
    end else begin
      word_q <= word_d;
      vld_q  <= vld_d;
    end
  end

  assign q.vld  = vld_q;
  assign q.data = word_q;

endmodule

// File: rtl/ram8x8.sv
// 8 x 8-bit RAM: one synchronous write port, one combinational read port.
// Ports: clk, rst (sync, active-high), WE/WA/DIN (write), RA (read address),
//        D (read data, combinational), V (word RA written since reset, combinational).
// Optional: define RAM8X8_BYPASS_EN to forward DIN onto D (with V=1) when a
//           write targets the address being read in the same cycle.
module ram8x8
  import ram8x8_pkg::*;
#(
  parameter data_t RST_VAL = RST_VAL_DEFAULT
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  WE,
  input  addr_t WA,
  input  data_t DIN,
  input  addr_t RA,
  output data_t D,
  output logic  V
);

  logic [DEPTH-1:0] wr_en_c;
  entry_t           word_ent [DEPTH];
  entry_t           lvl1     [DEPTH/2];
  entry_t           lvl2     [DEPTH/4];
  entry_t           tree_c;
  entry_t           rd_c;

  // Write decode gated by WE; an unknown WA cannot reach a word while WE=0.
  assign wr_en_c = dec_onehot(WA) & {DEPTH{WE}};

  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    ram8x8_reg8_en #(
      .RST_VAL (RST_VAL)
    ) u_word (
      .clk (clk),
      .rst (rst),
      .en  (wr_en_c[i]),
      .din (DIN),
      .q   (word_ent[i])
    );
  end

  // Read tree: RA[0] picks within pairs, RA[1] within quads, RA[2] the half.
  for (genvar j = 0; j < DEPTH/2; j++) begin : g_lvl1
    assign lvl1[j] = mux2(word_ent[2*j], word_ent[2*j+1], RA[0]);
  end
  for (genvar k = 0; k < DEPTH/4; k++) begin : g_lvl2
    assign lvl2[k] = mux2(lvl1[2*k], lvl1[2*k+1], RA[1]);
  end
  assign tree_c = mux2(lvl2[0], lvl2[1], RA[2]);

  // Read output, optionally forwarding an in-flight write to the same word.
  always_comb begin
    rd_c = tree_c;
`ifdef RAM8X8_BYPASS_EN
    if (WE && !rst && (RA == WA)) begin
      rd_c.vld  = 1'b1;
      rd_c.data = DIN;
    end
`endif
  end

  assign D = rd_c.data;
  assign V = rd_c.vld;

endmodule

// File: tb/tb_ram8x8.sv
module tb_ram8x8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       WE  = 1'b0;
  logic [2:0] WA  = 3'd0;
  logic [2:0] RA  = 3'd0;
  logic [7:0] DIN = 8'h00;
  logic [7:0] D;
  logic       V;

  ram8x8 dut (
    .clk (clk),
    .rst (rst),
    .WE  (WE),
    .WA  (WA),
    .DIN (DIN),
    .RA  (RA),
    .D   (D),
    .V   (V)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] d;
    logic       v;
  } exp_t;

  typedef struct {
    logic       we;
    logic [2:0] wa;
    logic [7:0] din;
    logic [2:0] ra;
    logic [7:0] exp_d;
    logic       exp_v;
    string      name;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[24];
  int   tests = 0;
  int   fails = 0;

  task automatic push_exp(input logic [7:0] d, input logic v);
    exp_t e;
    e.d = d;
    e.v = v;
    sb_q.push_back(e);
  endtask

  task automatic check(input string name);
    exp_t e;
    tests++;
    if (sb_q.size() == 0) begin
      fails++;
      $display("FAIL %s: no expected value queued (D=%h V=%b)", name, D, V);
    end else begin
      e = sb_q.pop_front();
      if (D !== e.d || V !== e.v) begin
        fails++;
        $display("FAIL %s: RA=%0d got D=%h V=%b, expected D=%h V=%b",
                 name, RA, D, V, e.d, e.v);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic read_chk(input logic [2:0] a, input logic [7:0] d, input logic v,
                          input string name);
    RA = a;
    push_exp(d, v);
    #1;
    check(name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Vector table: reset sweep, write sweep (pre-edge read), read-back sweep.
    for (int i = 0; i < 8; i++) begin
      vecs[i] = '{1'b0, 3'd0, 8'h00, 3'(i), 8'h00, 1'b0, "reset_sweep"};
`ifdef RAM8X8_BYPASS_EN
      vecs[8+i] = '{1'b1, 3'(i), 8'hA0 + 8'(i), 3'(i), 8'hA0 + 8'(i), 1'b1, "write_sweep"};
`else
      vecs[8+i] = '{1'b1, 3'(i), 8'hA0 + 8'(i), 3'(i), 8'h00, 1'b0, "write_sweep"};
`endif
      vecs[16+i] = '{1'b0, 3'd7 - 3'(i), 8'h00, 3'(i), 8'hA0 + 8'(i), 1'b1, "readback"};
    end

    rst = 1'b1;
    step();
    step();
    rst = 1'b0;

    foreach (vecs[n]) begin
      WE  = vecs[n].we;
      WA  = vecs[n].wa;
      DIN = vecs[n].din;
      RA  = vecs[n].ra;
      push_exp(vecs[n].exp_d, vecs[n].exp_v);
      #1;
      check(vecs[n].name);
      step();
    end
    WE = 1'b0;

    // Same-address read/write: old value before the edge (unless forwarded).
    WE  = 1'b1;
    WA  = 3'd3;
    DIN = 8'h5C;
`ifdef RAM8X8_BYPASS_EN
    read_chk(3'd3, 8'h5C, 1'b1, "same_addr_pre");
`else
    read_chk(3'd3, 8'hA3, 1'b1, "same_addr_pre");
`endif
    step();
    WE = 1'b0;
    read_chk(3'd3, 8'h5C, 1'b1, "same_addr_post");
    read_chk(3'd4, 8'hA4, 1'b1, "same_addr_neighbour");

    // Reset together with a write: the write is dropped, all words clear.
    rst = 1'b1;
    WE  = 1'b1;
    WA  = 3'd5;
    DIN = 8'hFF;
    step();
    rst = 1'b0;
    WE  = 1'b0;
    read_chk(3'd5, 8'h00, 1'b0, "rst_over_we");
    read_chk(3'd3, 8'h00, 1'b0, "rst_midop");

    // Back-to-back writes to word 6 with neighbours set first.
    WE  = 1'b1;
    WA  = 3'd5;
    DIN = 8'h55;
    step();
    WA  = 3'd7;
    DIN = 8'h77;
    step();
    WA  = 3'd6;
    DIN = 8'h11;
    step();
    DIN = 8'h22;
    step();
    WE = 1'b0;
    read_chk(3'd6, 8'h22, 1'b1, "b2b_last_wins");
    read_chk(3'd5, 8'h55, 1'b1, "b2b_neigh5");
    read_chk(3'd7, 8'h77, 1'b1, "b2b_neigh7");

    // Single write after reset: only that word becomes valid.
    rst = 1'b1;
    step();
    rst = 1'b0;
    WE  = 1'b1;
    WA  = 3'd2;
    DIN = 8'h3C;
    step();
    WE = 1'b0;
    for (int i = 0; i < 8; i++) begin
      read_chk(3'(i), (i == 2) ? 8'h3C : 8'h00, (i == 2), "single_write");
    end

    // Unknown WA with WE low leaves storage untouched.
    WA  = 3'bxxx;
    DIN = 8'hEE;
    step();
    step();
    read_chk(3'd2, 8'h3C, 1'b1, "x_wa_hold2");
    read_chk(3'd0, 8'h00, 1'b0, "x_wa_hold0");

    if (sb_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
